// File: rtl/vga_pkg.sv
// vga_pkg: VGA timing constants, write-window state and access-owner tags shared by the VRAM path.
package vga_pkg;
  localparam int H_TOTAL = 800;
  localparam int V_TOTAL = 525;
  localparam int V_VIS_FIRST = 35;
  localparam int V_VIS_LAST = 515;
  typedef enum logic {LOCKED, OPEN} win_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_CLIENT} owner_e;
  function automatic logic in_blank(input logic [9:0] v);
    return v < 10'(V_VIS_FIRST) || v > 10'(V_VIS_LAST);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick among eligible requesters, searching from last_gnt+1.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NREQ-1:0] elig,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  logic [IW-1:0] last;
  logic [IW-1:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c = '0;
    for (int k = 1; k <= NREQ; k++) begin
      c = IW'((int'(last) + k) % NREQ);
      if (en && !any && elig[c]) begin
        gnt[c] = 1'b1;
        idx = c;
        any = 1'b1;
      end
    end
  end
  // Only real client grants rotate the pointer; display slots leave it alone.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) last <= IW'(NREQ - 1);
    else if (any) last <= idx;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM shared by display fetch (absolute priority) and round-robin clients,
// with client writes held off during visible lines.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8,
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pix_tick,
  input  logic [9:0]               vCount,
  input  logic                     disp_req,
  input  logic [ADDR_W-1:0]        disp_addr,
  output logic [DATA_W-1:0]        disp_data,
  output logic                     disp_valid,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          rvalid,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata
);
  win_e state, state_nx;
  owner_e own_q, own_nx;
  logic [IW-1:0] idx_q, gidx;
  logic [DATA_W-1:0] disp_q, rd_q;
  logic [NREQ-1:0] elig;
  logic disp_win, arb_en, any, cli_we;
  // Combinational outputs are gated by rst_n so everything reads 0 while in reset.
  assign disp_win = rst_n & pix_tick & disp_req;
  assign arb_en = rst_n & ~(pix_tick & disp_req);
  for (genvar g = 0; g < NREQ; g++) begin : g_elig
    assign elig[g] = req[g] & (~we[g] | (state == OPEN));
  end
  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk(clk),
    .rst_n(rst_n),
    .en(arb_en),
    .elig(elig),
    .gnt(gnt),
    .idx(gidx),
    .any(any)
  );
  always_comb begin
    state_nx = in_blank(vCount) ? OPEN : LOCKED;
    cli_we = any & we[gidx];
    mem_en = disp_win | any;
    mem_we = cli_we;
    mem_addr = disp_win ? disp_addr : any ? addr[gidx*ADDR_W +: ADDR_W] : '0;
    mem_wdata = cli_we ? wdata[gidx*DATA_W +: DATA_W] : '0;
    own_nx = disp_win ? OWN_DISP : (any & ~cli_we) ? OWN_CLIENT : OWN_NONE;
  end
  // Return data is shown straight from the RAM in the tagged cycle and held afterwards.
  assign disp_valid = own_q == OWN_DISP;
  assign disp_data = disp_valid ? mem_rdata : disp_q;
  assign rvalid = own_q == OWN_CLIENT ? NREQ'(1) << idx_q : '0;
  assign rdata = own_q == OWN_CLIENT ? mem_rdata : rd_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= LOCKED;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      own_q <= OWN_NONE;
      idx_q <= '0;
      disp_q <= '0;
      rd_q <= '0;
    end else begin
      own_q <= own_nx;
      idx_q <= gidx;
      if (disp_valid) disp_q <= mem_rdata;
      if (own_q == OWN_CLIENT) rd_q <= mem_rdata;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a behavioural model.
module tb_vram_arbiter;
  localparam int N = 2, AW = 12, DW = 8;
  logic clk = 0, rst_n = 0, pix_tick = 0, disp_req = 0;
  logic [9:0] vCount = 0;
  logic [AW-1:0] disp_addr = 0;
  logic [N-1:0] req = 0, we = 0;
  logic [N*AW-1:0] addr = 0;
  logic [N*DW-1:0] wdata = 0;
  logic [DW-1:0] disp_data, rdata, mem_wdata, mem_rdata = 0;
  logic disp_valid, mem_en, mem_we;
  logic [N-1:0] gnt, rvalid;
  logic [AW-1:0] mem_addr;
  logic [2:0] req3 = 0, we3 = 0, gnt3, rvalid3;
  logic [3*AW-1:0] addr3 = 0;
  logic [3*DW-1:0] wdata3 = 0;
  logic [DW-1:0] dd3, rd3, mwd3, zero8 = 0;
  logic dv3, men3, mwe3;
  logic [AW-1:0] ma3;
  logic [DW-1:0] ram [4096];
  logic [DW-1:0] sh [4096];
  int checks = 0, errors = 0;
  int m_last, m_kind, m_idx, exp_gidx;
  bit m_open;
  logic [DW-1:0] m_data, m_dhold, m_rhold;
  logic [N-1:0] exp_gnt, exp_rvalid;
  logic exp_en, exp_we, exp_dvalid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd, exp_rdata, exp_ddata;

  vram_arbiter #(.NREQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_tick(pix_tick), .vCount(vCount), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid), .req(req), .we(we),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  vram_arbiter #(.NREQ(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .pix_tick(1'b0), .vCount(10'd520), .disp_req(1'b0),
    .disp_addr(12'h0), .disp_data(dd3), .disp_valid(dv3), .req(req3), .we(we3),
    .addr(addr3), .wdata(wdata3), .gnt(gnt3), .rdata(rd3), .rvalid(rvalid3), .mem_en(men3),
    .mem_we(mwe3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(zero8)
  );

  always #5 clk = ~clk;
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  // Expected outputs for the current inputs from the arbitration rules.
  task automatic calc();
    exp_gnt = '0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wd = '0; exp_gidx = -1;
    if (!rst_n) begin m_last = N - 1; m_open = 0; m_kind = 0; m_dhold = 0; m_rhold = 0; end
    exp_dvalid = m_kind == 1;
    exp_ddata = m_kind == 1 ? m_data : m_dhold;
    exp_rvalid = m_kind == 2 ? N'(1) << m_idx : '0;
    exp_rdata = m_kind == 2 ? m_data : m_rhold;
    if (!rst_n) return;
    if (pix_tick && disp_req) begin exp_en = 1; exp_addr = disp_addr; end
    else for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (exp_gidx < 0 && req[i] && (!we[i] || m_open)) begin
        exp_gidx = i; exp_gnt[i] = 1; exp_en = 1; exp_we = we[i];
        exp_addr = addr[i*AW +: AW];
        exp_wd = we[i] ? wdata[i*DW +: DW] : '0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin m_last = N - 1; m_open = 0; m_kind = 0; m_dhold = 0; m_rhold = 0; end
    else begin
      if (m_kind == 1) m_dhold = m_data;
      if (m_kind == 2) m_rhold = m_data;
      m_open = vCount >= 516 || vCount <= 34;
      m_kind = 0;
      if (pix_tick && disp_req) begin m_kind = 1; m_data = sh[disp_addr]; end
      else if (exp_gidx >= 0) begin
        m_last = exp_gidx;
        if (exp_we) sh[exp_addr] = exp_wd;
        else begin m_kind = 2; m_idx = exp_gidx; m_data = sh[exp_addr]; end
      end
    end
    #1;
  endtask

  task automatic settle();
    #3;
    calc();
  endtask

  task automatic set_cli(input int i, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w; addr[i*AW +: AW] = a; wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    set_cli(0, 1, 1, 12'h010, 8'hA5);
    set_cli(1, 1, 0, 12'h020, 8'h00);
    pix_tick = 1; disp_req = 1;
    settle();
    checks += 6;
    if (gnt !== 0) begin errors++; $display("FAIL reset_gnt got %b want 0", gnt); end
    if (mem_en !== 0 || mem_we !== 0) begin errors++; $display("FAIL reset_strobes got en=%b we=%b want 0", mem_en, mem_we); end
    if (mem_addr !== 0 || mem_wdata !== 0) begin errors++; $display("FAIL reset_mem got addr=%h wdata=%h want 0", mem_addr, mem_wdata); end
    if (rvalid !== 0 || disp_valid !== 0) begin errors++; $display("FAIL reset_valid got rvalid=%b dv=%b want 0", rvalid, disp_valid); end
    if (rdata !== 0 || disp_data !== 0) begin errors++; $display("FAIL reset_data got rdata=%h dd=%h want 0", rdata, disp_data); end
    if (dut3.gnt !== 0) begin errors++; $display("FAIL reset_gnt3 got %b want 0", gnt3); end
    pix_tick = 0; disp_req = 0;
    set_cli(1, 0, 0, 12'h0, 8'h0);
    tick();
  endtask

  task automatic test_write_read();
    int c;
    vCount = 520;
    tick();
    rst_n = 1;
    settle();
    for (c = 0; c < 5 && gnt !== 2'b01; c++) begin tick(); settle(); end
    checks += 3;
    if (gnt !== 2'b01 || exp_gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt got %b want 01", gnt); end
    if (mem_we !== 1 || mem_addr !== 12'h010 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL wr_mem got we=%b addr=%h data=%h want 1 010 a5", mem_we, mem_addr, mem_wdata); end
    if (c > 2) begin errors++; $display("FAIL wr_latency got %0d cycles want <=2", c); end
    tick();
    set_cli(0, 0, 0, 12'h0, 8'h0);
    set_cli(1, 1, 0, 12'h010, 8'h0);
    settle();
    checks++;
    if (gnt !== 2'b10 || mem_we !== 0) begin errors++; $display("FAIL rd_gnt got %b we=%b want 10 0", gnt, mem_we); end
    tick();
    set_cli(1, 0, 0, 12'h0, 8'h0);
    settle();
    checks++;
    if (rvalid !== 2'b10 || rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got rvalid=%b rdata=%h want 10 a5", rvalid, rdata); end
    tick();
  endtask

  task automatic test_locked();
    vCount = 100;
    tick(); tick();
    set_cli(0, 1, 1, 12'h020, 8'h77);
    set_cli(1, 1, 0, 12'h010, 8'h00);
    settle();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL lock_read got %b want 10", gnt); end
    tick();
    set_cli(1, 0, 0, 12'h0, 8'h0);
    for (int k = 0; k < 6; k++) begin
      settle();
      checks++;
      if (gnt !== 0 || mem_en !== 0) begin errors++; $display("FAIL lock_hold got gnt=%b en=%b want 0", gnt, mem_en); end
      tick();
    end
    vCount = 516;
    settle();
    checks++;
    if (gnt !== 0) begin errors++; $display("FAIL lock_edge got %b want 0", gnt); end
    tick();
    settle();
    checks++;
    if (gnt !== 2'b01 || mem_we !== 1 || mem_addr !== 12'h020 || mem_wdata !== 8'h77) begin
      errors++; $display("FAIL open_write got gnt=%b we=%b addr=%h data=%h want 01 1 020 77", gnt, mem_we, mem_addr, mem_wdata);
    end
    tick();
    set_cli(0, 0, 0, 12'h0, 8'h0);
  endtask

  task automatic test_rr();
    int cnt0 = 0, cnt1 = 0;
    logic [N-1:0] prev;
    vCount = 520;
    set_cli(0, 1, 0, 12'h030, 8'h0);
    set_cli(1, 1, 0, 12'h031, 8'h0);
    settle();
    prev = 2'b01;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (gnt !== exp_gnt || gnt === prev) begin errors++; $display("FAIL rr_alt got %b want %b", gnt, exp_gnt); end
      cnt0 += int'(gnt[0]); cnt1 += int'(gnt[1]);
      prev = gnt;
      tick(); settle();
    end
    checks++;
    if (cnt0 != 2 || cnt1 != 2) begin errors++; $display("FAIL rr_share got %0d/%0d want 2/2", cnt0, cnt1); end
  endtask

  task automatic test_display();
    disp_addr = 12'h123; disp_req = 1;
    for (int k = 0; k < 16; k++) begin
      pix_tick = k % 4 == 0;
      settle();
      checks++;
      if (pix_tick && (gnt !== 0 || mem_addr !== 12'h123 || mem_we !== 0)) begin
        errors++; $display("FAIL disp_slot got gnt=%b addr=%h want 0 123", gnt, mem_addr);
      end
      if (k % 4 == 1 && (disp_valid !== 1 || disp_data !== 8'h5C)) begin
        errors++; $display("FAIL disp_ret got dv=%b dd=%h want 1 5c", disp_valid, disp_data);
      end
      if (!pix_tick && (gnt !== exp_gnt || rvalid !== exp_rvalid)) begin
        errors++; $display("FAIL disp_cli got gnt=%b rv=%b want %b %b", gnt, rvalid, exp_gnt, exp_rvalid);
      end
      tick();
    end
    pix_tick = 0; disp_req = 0;
    set_cli(0, 0, 0, 12'h0, 8'h0);
    set_cli(1, 0, 0, 12'h0, 8'h0);
    settle();
    checks++;
    if (disp_data !== 8'h5C || disp_valid !== 0) begin errors++; $display("FAIL disp_hold got dd=%h dv=%b want 5c 0", disp_data, disp_valid); end
    tick();
  endtask

  task automatic test_reset_mid_read();
    set_cli(0, 1, 0, 12'h123, 8'h0);
    settle();
    checks++;
    if (gnt === 0) begin errors++; $display("FAIL mid_gnt got %b want nonzero", gnt); end
    #1 rst_n = 0;
    set_cli(0, 0, 0, 12'h0, 8'h0);
    for (int k = 0; k < 6; k++) begin
      if (k == 3) rst_n = 1;
      tick(); settle();
      checks++;
      if (rvalid !== 0 || disp_valid !== 0 || (k < 3 && (rdata !== 0 || disp_data !== 0 || mem_en !== 0))) begin
        errors++; $display("FAIL mid_reset got rv=%b dv=%b rdata=%h dd=%h en=%b want 0", rvalid, disp_valid, rdata, disp_data, mem_en);
      end
    end
  endtask

  task automatic test_nreq3();
    req3 = 3'b100;
    #4;
    checks++;
    if (gnt3 !== 3'b100) begin errors++; $display("FAIL n3_solo got %b want 100", gnt3); end
    @(posedge clk); #1;
    req3 = 3'b111;
    #4;
    checks++;
    if (gnt3 !== 3'b001) begin errors++; $display("FAIL n3_wrap got %b want 001", gnt3); end
    @(posedge clk); #1;
    req3 = 3'b110;
    #4;
    checks++;
    if (gnt3 !== 3'b010) begin errors++; $display("FAIL n3_next got %b want 010", gnt3); end
    @(posedge clk); #1;
    req3 = 0;
  endtask

  task automatic test_random();
    bit pend [N];
    int vl [7] = '{10, 34, 35, 100, 515, 516, 520};
    for (int i = 0; i < N; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      if (c % 37 == 0) vCount = 10'(vl[$urandom_range(0, 6)]);
      pix_tick = c % 4 == 0;
      disp_req = $urandom_range(0, 1);
      disp_addr = 12'($urandom_range(0, 4095));
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1;
          set_cli(i, 1, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), 8'($urandom));
        end else if (!pend[i]) req[i] = 0;
      settle();
      checks++;
      if (gnt !== exp_gnt || mem_en !== exp_en || mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wd) begin
        errors++; $display("FAIL rnd_issue c=%0d got gnt=%b en=%b we=%b a=%h d=%h want %b %b %b %h %h",
          c, gnt, mem_en, mem_we, mem_addr, mem_wdata, exp_gnt, exp_en, exp_we, exp_addr, exp_wd);
      end
      if (rvalid !== exp_rvalid || rdata !== exp_rdata || disp_valid !== exp_dvalid || disp_data !== exp_ddata) begin
        errors++; $display("FAIL rnd_return c=%0d got rv=%b rd=%h dv=%b dd=%h want %b %h %b %h",
          c, rvalid, rdata, disp_valid, disp_data, exp_rvalid, exp_rdata, exp_dvalid, exp_ddata);
      end
      for (int i = 0; i < N; i++) if (exp_gnt[i]) pend[i] = 0;
      tick();
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin ram[a] = 8'(a) ^ 8'h3C; sh[a] = 8'(a) ^ 8'h3C; end
    ram[12'h123] = 8'h5C; sh[12'h123] = 8'h5C;
    test_reset();
    test_write_read();
    test_locked();
    test_rr();
    test_display();
    test_reset_mid_read();
    test_nreq3();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
